// File: rtl/image_compressor.sv
// Block-averaging downsampler: folds each BLKxBLK tile of a 1-bit scanned canvas into one
// 8-bit intensity and writes it to the compressed-image memory as the scan goes past.
module image_compressor #(
  parameter int SRC_DIM = 224,
  parameter int BLK     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       compress_start,
  input  logic       scan_en,
  input  logic [7:0] scan_x,
  input  logic [7:0] scan_y,
  input  logic       pix,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done
);

  // BLK must be a power of two between 2 and 16 so a full tile maps exactly onto 0..256.
  localparam int         OUT_DIM  = SRC_DIM / BLK;
  localparam int         SH       = $clog2(BLK);
  localparam int         ACC_W    = $clog2(BLK * BLK + 1);
  localparam int         IDX_W    = $clog2(OUT_DIM);
  localparam int         SCALE_SH = 8 - 2 * SH;
  localparam logic [7:0] LAST     = 8'(SRC_DIM - 1);

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc [OUT_DIM];
  logic             r_wr_en;
  logic [9:0]       r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_done;

  logic             w_accept;
  logic             w_start;
  logic             w_capture;
  logic             w_blk_end;
  logic             w_last;
  logic [IDX_W-1:0] w_col;
  logic [IDX_W-1:0] w_row;
  logic [ACC_W-1:0] w_sum;
  logic [8:0]       w_scaled;
  logic [7:0]       w_data;
  logic [9:0]       w_row_ext;
  logic [9:0]       w_addr;

  assign w_accept  = scan_en && (scan_x <= LAST) && (scan_y <= LAST);
  assign w_start   = (r_state == IDLE) && w_accept && compress_start &&
                     (scan_x == 8'd0) && (scan_y == 8'd0);
  assign w_capture = (r_state == CAPTURE) && w_accept;
  assign w_blk_end = (&scan_x[SH-1:0]) && (&scan_y[SH-1:0]);
  assign w_last    = (scan_x == LAST) && (scan_y == LAST);

  assign w_col     = IDX_W'(scan_x >> SH);
  assign w_row     = IDX_W'(scan_y >> SH);
  assign w_sum     = r_acc[w_col] + ACC_W'(pix);

  // A full tile sums to exactly 256 after scaling, which is the only value needing saturation.
  assign w_scaled  = 9'(w_sum) << SCALE_SH;
  assign w_data    = w_scaled[8] ? 8'hFF : w_scaled[7:0];
  assign w_row_ext = 10'(w_row);

  generate
    if (OUT_DIM == 28) begin : g_addr28
      assign w_addr = (w_row_ext << 5) - (w_row_ext << 2) + 10'(w_col);
    end else begin : g_addr_gen
      assign w_addr = (w_row_ext * 10'(OUT_DIM)) + 10'(w_col);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = CAPTURE;
      CAPTURE: if (w_capture && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One accumulator per tile column; a row of tiles reuses them after each tile is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DIM; i++) r_acc[i] <= '0;
    end else if (w_start) begin
      for (int i = 0; i < OUT_DIM; i++) r_acc[i] <= '0;
      r_acc[0] <= ACC_W'(pix);
    end else if (w_capture) begin
      r_acc[w_col] <= w_blk_end ? '0 : w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= w_capture && w_blk_end;
      r_done  <= w_capture && w_last;
      if (w_capture && w_blk_end) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign done    = r_done;
  assign busy    = (r_state == CAPTURE);

endmodule

// File: tb/tb_image_compressor.sv
// Directed bench for image_compressor on a 56x56 canvas with 2x2 tiles, which keeps the
// 28x28 output (addresses 0..783) while each frame stays short.
module tb_image_compressor;

  localparam int SRC_DIM = 56;
  localparam int BLK     = 2;
  localparam int NBLK    = 784;
  localparam int OOR     = 4;
  localparam int FRAME_CYCLES = (SRC_DIM - 1) * (SRC_DIM + OOR) + SRC_DIM;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       compress_start = 1'b0;
  logic       scan_en = 1'b0;
  logic [7:0] scan_x = '0;
  logic [7:0] scan_y = '0;
  logic       pix = 1'b0;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;

  image_compressor #(.SRC_DIM(SRC_DIM), .BLK(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .compress_start(compress_start), .scan_en(scan_en),
    .scan_x(scan_x), .scan_y(scan_y), .pix(pix),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int         assertCount = 0;
  int         failCount = 0;
  logic [9:0] addrQ[$];
  logic [7:0] dataQ[$];
  int         doneCount = 0;
  int         doneBad = 0;
  int         busyCycles = 0;
  int         qBase, doneBase, doneBadBase, busyBase;

  // Record every write and done pulse in the middle of the cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      addrQ.push_back(wr_addr);
      dataQ.push_back(wr_data);
    end
    if (done) begin
      doneCount++;
      if (busy || !wr_en || wr_addr != 10'd783) doneBad++;
    end
    if (busy) busyCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  function automatic logic pixOf(input int mode, input int x, input int y);
    if (x >= SRC_DIM) return 1'b1;
    case (mode)
      1:       return 1'b1;
      2:       return (x == 9 && y == 17);
      3:       return 1'(x ^ y);
      default: return 1'b0;
    endcase
  endfunction

  task automatic snapshot();
    qBase       = addrQ.size();
    doneBase    = doneCount;
    doneBadBase = doneBad;
    busyBase    = busyCycles;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      scan_en = 1'b0;
      compress_start = 1'b0;
    end
  endtask

  // Raster one frame; columns past the canvas edge are driven valid but must be ignored.
  // startMask: bit0 start at (0,0), bit1 at (5,0), bit2 at (0,25). abortAt>0 resets at (abortAt,abortAt).
  task automatic applyStimulus(input int mode, input int gapPct, input int startMask, input int abortAt);
    for (int y = 0; y < SRC_DIM; y++) begin
      for (int x = 0; x < ((y == SRC_DIM - 1) ? SRC_DIM : SRC_DIM + OOR); x++) begin
        if (abortAt > 0 && x == abortAt && y == abortAt) begin
          @(posedge clk); #1;
          scan_en = 1'b0;
          rst_n = 1'b0;
          @(posedge clk);
          @(posedge clk); #1;
          rst_n = 1'b1;
          return;
        end
        if (gapPct > 0 && !(x == 0 && y == 0)) begin
          for (int g = 0; g < 3 && $urandom_range(99) < gapPct; g++) begin
            @(posedge clk); #1;
            scan_en = 1'b0;
            compress_start = 1'b0;
            scan_x = 8'($urandom_range(255));
            pix = 1'($urandom_range(1));
          end
        end
        @(posedge clk); #1;
        scan_en = 1'b1;
        scan_x = 8'(x);
        scan_y = 8'(y);
        pix = pixOf(mode, x, y);
        compress_start = (startMask[0] && x == 0 && y == 0) ||
                         (startMask[1] && x == 5 && y == 0) ||
                         (startMask[2] && x == 0 && y == 25);
      end
    end
  endtask

  // Check NBLK writes starting at offset: addresses in order, data = base except one special address.
  task automatic checkFrame(input string tag, input int offset, input logic [7:0] base,
                            input int specAddr, input logic [7:0] specData);
    int addrErr = 0;
    int dataErr = 0;
    for (int i = 0; i < NBLK; i++) begin
      if (qBase + offset + i >= addrQ.size()) begin
        addrErr++;
        dataErr++;
      end else begin
        if (addrQ[qBase + offset + i] != 10'(i)) addrErr++;
        if (dataQ[qBase + offset + i] != ((i == specAddr) ? specData : base)) dataErr++;
      end
    end
    checkOutput({tag, "_addrOrder"}, addrErr, 0);
    checkOutput({tag, "_dataBad"}, dataErr, 0);
  endtask

  initial begin
    #2;
    @(negedge clk);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    snapshot();
    applyStimulus(1, 0, 0, 0);
    idleCycles(4);
    checkOutput("idle_writes", addrQ.size() - qBase, 0);
    checkOutput("idle_done", doneCount - doneBase, 0);
    checkOutput("idle_busy", busyCycles - busyBase, 0);

    snapshot();
    applyStimulus(1, 0, 1, 0);
    idleCycles(4);
    checkOutput("ones_count", addrQ.size() - qBase, NBLK);
    checkFrame("ones", 0, 8'hFF, -1, 8'h00);
    checkOutput("ones_done", doneCount - doneBase, 1);
    checkOutput("ones_doneAlign", doneBad - doneBadBase, 0);
    checkOutput("ones_busyCycles", busyCycles - busyBase, FRAME_CYCLES - 1);
    checkOutput("ones_busyAfter", busy, 0);
    checkOutput("ones_holdAddr", wr_addr, 10'd783);
    checkOutput("ones_holdData", wr_data, 8'hFF);

    snapshot();
    applyStimulus(2, 0, 1, 0);
    idleCycles(4);
    checkOutput("single_count", addrQ.size() - qBase, NBLK);
    checkFrame("single", 0, 8'h00, 228, 8'h40);
    checkOutput("single_done", doneCount - doneBase, 1);

    snapshot();
    applyStimulus(1, 0, 1, 0);
    applyStimulus(3, 25, 1, 0);
    idleCycles(4);
    checkOutput("b2b_count", addrQ.size() - qBase, 2 * NBLK);
    checkFrame("b2b_ones", 0, 8'hFF, -1, 8'h00);
    checkFrame("b2b_checker", NBLK, 8'h80, -1, 8'h00);
    checkOutput("b2b_done", doneCount - doneBase, 2);
    checkOutput("b2b_doneAlign", doneBad - doneBadBase, 0);

    snapshot();
    applyStimulus(1, 0, 2, 0);
    idleCycles(4);
    checkOutput("lateStart_writes", addrQ.size() - qBase, 0);
    checkOutput("lateStart_busy", busyCycles - busyBase, 0);

    snapshot();
    applyStimulus(1, 0, 5, 0);
    idleCycles(4);
    checkOutput("restart_count", addrQ.size() - qBase, NBLK);
    checkFrame("restart", 0, 8'hFF, -1, 8'h00);
    checkOutput("restart_done", doneCount - doneBase, 1);

    snapshot();
    applyStimulus(1, 0, 1, 25);
    idleCycles(2);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_wr_en", wr_en, 0);
    checkOutput("abort_wr_addr", wr_addr, 0);
    checkOutput("abort_wr_data", wr_data, 0);
    checkOutput("abort_done", doneCount - doneBase, 0);

    snapshot();
    applyStimulus(1, 0, 1, 0);
    idleCycles(4);
    checkOutput("fresh_count", addrQ.size() - qBase, NBLK);
    checkFrame("fresh", 0, 8'hFF, -1, 8'h00);
    checkOutput("fresh_done", doneCount - doneBase, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/image_compressor.md
# image_compressor

Downsamples one 224x224 1-bit canvas frame into a 28x28 8-bit intensity image for the recognition network, riding on the continuous canvas scan. It sits directly downstream of the compress request logic: it consumes `compress_start` and the same scan coordinates that block watches, and writes one compressed pixel per 8x8 source block into the compressed-image memory. `busy` high corresponds to the request logic's in-process window, which spans (0,0) through (223,223).

## Interface

Parameters:
- `SRC_DIM`, default 224: source frame width and height in pixels.
- `BLK`, default 8: block edge. `OUT_DIM = SRC_DIM/BLK` = 28, a derived localparam.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `compress_start`  in  1  start request from the compress request logic; level, may stay high for several cycles.
- `scan_en`  in  1  qualifies `scan_x`, `scan_y` and `pix` as a valid scan sample this cycle.
- `scan_x`  in  8  scan column.
- `scan_y`  in  8  scan row.
- `pix`  in  1  canvas pixel at (`scan_x`, `scan_y`), already aligned with the address.
- `wr_en`  out  1  one-cycle write strobe to the compressed memory.
- `wr_addr`  out  10  compressed pixel address, `r*28 + c`, range 0..783.
- `wr_data`  out  8  compressed intensity.
- `busy`  out  1  frame capture in progress.
- `done`  out  1  one-cycle pulse after the last block (address 783) is written.

## Operation

- **States**: IDLE and CAPTURE.
- **Accepted sample**: `scan_en` is high and `scan_x` < 224 and `scan_y` < 224. Samples that fail these conditions are ignored in every state.
- **IDLE to CAPTURE**: requires `compress_start` high, an accepted sample, and `scan_x` = `scan_y` = 0.
  - That (0,0) sample is accumulated.
  - All 28 accumulators are cleared in the same edge; `acc[0]` loads `pix`.
  - `compress_start` is ignored in CAPTURE.
- **Accumulators**: 28 column accumulators, 7 bits each (range 0..64), indexed `c = scan_x >> 3`, with `r = scan_y >> 3`.
  - Each accepted sample in CAPTURE adds `pix` to `acc[c]`.
- **Block completion**: occurs on an accepted sample with `scan_x[2:0]` = 7 and `scan_y[2:0]` = 7.
  - `sum = acc[c] + pix`.
  - `wr_data = min(sum*4, 255)`: 64 saturates to 0xFF, 32 gives 0x80.
  - `wr_addr = r*28 + c`, computed without a multiplier: `r*28 = (r<<5) - (r<<2)`.
  - `acc[c]` is cleared in the same edge.
- **CAPTURE to IDLE**: on the accepted sample at (223,223), after its block completes.
- **Scan order**: raster order is assumed by the design. Gaps in `scan_en` simply stall accumulation. Missing pixels count as 0; no error is flagged.
- **Reset** (asynchronous, including mid-frame): returns to IDLE, clears accumulators, and drives all outputs to 0. A partial frame is discarded, with no `done`.

## Timing

- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
- `busy` rises one cycle after the edge that accepts the start sample.
- `wr_en`, `wr_addr` and `wr_data` are registered: they are valid for exactly one cycle, starting one cycle after the completing sample is sampled. `wr_addr` and `wr_data` hold their last values otherwise.
- Frame end: `wr_en` (addr 783), `done` and `busy` falling all occur in the same cycle, one cycle after the (223,223) sample.
- Back-to-back frames: a start at (0,0) is accepted on any cycle where `busy` is already low, including the cycle `done` is high.
- Throughput: one sample per cycle; at most one write per cycle. Writes are at least 8 accepted samples apart.

## Test plan

- Reset, then idle stimulus with `compress_start`=0 for a full frame -> all outputs stay 0, no `wr_en`.
- All-ones frame, `scan_en` always high, `compress_start` high at (0,0) -> 784 writes, addresses 0..783 in order, each with `wr_data`=0xFF; a single `done` coincident with addr 783; `busy` low afterward.
- All-zero frame except `pix`=1 at (9,17) -> addr 57 gets 0x04; every other address gets 0x00.
- Checkerboard frame (`pix` = `x[0]^y[0]`) with random `scan_en` gaps -> all 784 writes are 0x80, in the same address order.
- `compress_start` high at (5,0), then high during CAPTURE at (0,100) -> the first is ignored (no capture until the next (0,0)); the second does not restart, and the frame completes normally.
- `rst_n` pulsed low at (100,100) mid-frame, then a fresh all-ones frame -> no `done` for the aborted frame; the new frame yields 784 writes of 0xFF with no residue from the aborted frame.
